// File: rtl/mem_io_ctrl_pkg.sv
// Shared constants and types for the unified memory / memory-mapped I/O block.
package mem_io_pkg;

  // Word offsets inside the I/O window, relative to IO_BASE.
  localparam int OFF_RAND    = 0;
  localparam int OFF_STATUS  = 1;
  localparam int OFF_SNAP    = 2;
  localparam int OFF_FLAGCLR = 3;
  localparam int OFF_PLAYER  = 4;

  // Galois feedback mask for the 16-bit maximal-length random source.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Which part of the data address space an access lands in.
  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_UNMAPPED
  } region_e;

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU-side bus: data port, instruction fetch port and the error pulse.
interface mem_io_ctrl_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16,
  parameter int PC_BITS   = 10
);
  logic                 en;
  logic                 memwrite;
  logic                 memread;
  logic                 link;
  logic [ADDR_BITS-1:0] adr;
  logic [WIDTH-1:0]     writedata;
  logic [PC_BITS-1:0]   pc;
  logic [WIDTH-1:0]     memdata;
  logic [WIDTH-1:0]     instruction;
  logic                 addr_err;

  modport master (
    output en, memwrite, memread, link, adr, writedata, pc,
    input  memdata, instruction, addr_err
  );

  modport slave (
    input  en, memwrite, memread, link, adr, writedata, pc,
    output memdata, instruction, addr_err
  );
endinterface

// File: rtl/mem_io_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR; loads the seed while rst is low.
module lfsr16
  import mem_io_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] state;

  // Shift right every cycle, folding the tap mask in when bit 0 falls out.
  always_ff @(posedge clk) begin
    if (!rst) state <= seed;
    else      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
  end

  assign out = state;

endmodule

// File: rtl/mem_io_ctrl.sv
// Unified instruction/data memory with a decoded I/O window holding the
// random source, player input latches with sticky flags and the SNAP trigger.
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int          WIDTH       = 16,
  parameter int          ADDR_BITS   = 16,
  parameter int          PC_BITS     = 10,
  parameter int          DEPTH       = 1024,
  parameter int          NUM_PLAYERS = 4,
  parameter int unsigned IO_BASE     = 32'hFF00,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter string       INIT_FILE   = ""
) (
  input  logic                         clk,
  input  logic                         rst,
  mem_io_ctrl_if.slave                 bus,
  input  logic [NUM_PLAYERS*WIDTH-1:0] player_in,
  input  logic [NUM_PLAYERS-1:0]       player_valid,
  output logic [WIDTH-1:0]             randomVal,
  output logic [NUM_PLAYERS*WIDTH-1:0] p_snap,
  output logic                         snap_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]       ram [DEPTH];
  logic [WIDTH-1:0]       player_q [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] flags;
  logic [15:0]            lfsr_val;

  logic [31:0]            adr_ext;
  logic [31:0]            io_off;
  region_e                region;
  logic                   rd_act;
  logic                   wr_act;
  logic                   is_snap;
  logic [NUM_PLAYERS-1:0] flag_clr;
  logic                   addr_err_nxt;
  logic [WIDTH-1:0]       rd_val;
  logic [PC_BITS-1:0]     pc_inc;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .out  (lfsr_val)
  );

  // Address decode, read mux and the flag-clear sources for this cycle.
  always_comb begin
    adr_ext      = 32'(bus.adr);
    io_off       = adr_ext - IO_BASE;
    region       = REG_UNMAPPED;
    rd_act       = rst & bus.en & bus.memread & ~bus.link;
    wr_act       = rst & bus.en & bus.memwrite;
    is_snap      = 1'b0;
    flag_clr     = '0;
    addr_err_nxt = 1'b0;
    rd_val       = '0;
    pc_inc       = bus.pc + 1'b1;

    if (adr_ext < 32'(DEPTH)) begin
      region = REG_RAM;
    end else if (adr_ext >= IO_BASE && io_off < 32'(OFF_PLAYER + NUM_PLAYERS)) begin
      region = REG_IO;
    end

    if (region == REG_RAM) begin
      rd_val = ram[AW'(adr_ext)];
    end else if (region == REG_IO) begin
      if (io_off == 32'(OFF_RAND))   rd_val = WIDTH'(lfsr_val);
      if (io_off == 32'(OFF_STATUS)) rd_val = WIDTH'(flags);
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (io_off == 32'(OFF_PLAYER + i)) begin
          rd_val      = player_q[i];
          flag_clr[i] = rd_act;
        end
      end
      // Writes to the read-only registers fall through here and are dropped.
      if (wr_act && io_off == 32'(OFF_SNAP)) begin
        is_snap  = 1'b1;
        flag_clr = '1;
      end
      if (wr_act && io_off == 32'(OFF_FLAGCLR)) begin
        flag_clr = flag_clr | bus.writedata[NUM_PLAYERS-1:0];
      end
    end else begin
      addr_err_nxt = rd_act | wr_act;
    end
  end

  // RAM write port; old data is what both read ports see this cycle.
  always_ff @(posedge clk) begin
    if (wr_act && region == REG_RAM) ram[AW'(adr_ext)] <= bus.writedata;
  end

  // Instruction fetch port, one cycle latency, zero beyond the RAM.
  always_ff @(posedge clk) begin
    if (!rst)                               bus.instruction <= '0;
    else if (32'(bus.pc) < 32'(DEPTH))      bus.instruction <= ram[AW'(bus.pc)];
    else                                    bus.instruction <= '0;
  end

  // Data-port result, player latches, sticky flags and the SNAP capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.memdata  <= '0;
      bus.addr_err <= 1'b0;
      randomVal    <= '0;
      p_snap       <= '0;
      snap_valid   <= 1'b0;
      flags        <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) player_q[i] <= '0;
    end else begin
      snap_valid   <= is_snap;
      bus.addr_err <= addr_err_nxt;
      // A new capture in the same cycle as a clear keeps the flag set.
      flags        <= (flags & ~flag_clr) | player_valid;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (player_valid[i]) player_q[i] <= player_in[i*WIDTH +: WIDTH];
      end
      if (bus.en && bus.link) bus.memdata <= WIDTH'(pc_inc);
      else if (rd_act)        bus.memdata <= rd_val;
      if (is_snap) begin
        randomVal <= bus.writedata;
        for (int i = 0; i < NUM_PLAYERS; i++) p_snap[i*WIDTH +: WIDTH] <= player_q[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Randomised bench for mem_io_ctrl against a behavioural memory/I-O model.
module tb_mem_io_ctrl;

  logic        clk;
  logic        rst;
  logic [63:0] player_in;
  logic [3:0]  player_valid;
  logic [15:0] randomVal;
  logic [63:0] p_snap;
  logic        snap_valid;

  mem_io_ctrl_if #(.WIDTH(16), .ADDR_BITS(16), .PC_BITS(10)) bus ();

  mem_io_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .player_in    (player_in),
    .player_valid (player_valid),
    .randomVal    (randomVal),
    .p_snap       (p_snap),
    .snap_valid   (snap_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state.
  logic [15:0] m_ram [1024];
  bit          m_init [1024];
  logic [15:0] m_play [4];
  bit   [3:0]  m_flags;
  logic [15:0] m_lfsr;

  // Expected outputs after the next edge.
  logic [15:0] e_memdata, e_instr, e_rand;
  logic [63:0] e_psnap;
  bit          e_snapv, e_aerr, e_instr_ok;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the memory-map rules to the inputs currently on the pins.
  task automatic model_cycle();
    int a, off;
    bit is_ram, is_io;
    logic [15:0] rdv;
    bit [3:0] clr, nf;
    if (!rst) begin
      e_memdata = 0; e_rand = 0; e_psnap = 0; e_snapv = 0; e_aerr = 0; e_instr_ok = 0;
      m_flags = 0; m_lfsr = 16'hACE1;
      for (int i = 0; i < 4; i++) m_play[i] = 0;
      return;
    end
    a      = int'(bus.adr);
    is_ram = (a < 1024);
    is_io  = (a >= 'hFF00) && (a < 'hFF08);
    off    = a - 'hFF00;
    e_instr    = m_ram[bus.pc];
    e_instr_ok = m_init[bus.pc];
    e_snapv = 0; e_aerr = 0; clr = 0;
    if (bus.en) begin
      if (bus.link) begin
        e_memdata = 16'((int'(bus.pc) + 1) % 1024);
      end else if (bus.memread) begin
        rdv = 0;
        if (is_ram) rdv = m_ram[a];
        else if (is_io) begin
          if (off == 0) rdv = m_lfsr;
          else if (off == 1) rdv = {12'h000, m_flags};
          else if (off >= 4) begin rdv = m_play[off-4]; clr[off-4] = 1'b1; end
        end else e_aerr = 1;
        e_memdata = rdv;
      end
      if (bus.memwrite) begin
        if (is_ram) begin m_ram[a] = bus.writedata; m_init[a] = 1; end
        else if (is_io) begin
          if (off == 2) begin
            e_rand = bus.writedata;
            for (int i = 0; i < 4; i++) e_psnap[16*i +: 16] = m_play[i];
            clr = 4'hF; e_snapv = 1;
          end else if (off == 3) clr = clr | bus.writedata[3:0];
        end else e_aerr = 1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (player_valid[i]) begin m_play[i] = player_in[16*i +: 16]; nf[i] = 1; end
      else nf[i] = m_flags[i] & ~clr[i];
    end
    m_flags = nf;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  task automatic compare_all();
    chk("memdata", bus.memdata, e_memdata);
    chk("addr_err", bus.addr_err, e_aerr);
    chk("snap_valid", snap_valid, e_snapv);
    chk("randomVal", randomVal, e_rand);
    chk("p_snap", p_snap, e_psnap);
    if (e_instr_ok) chk("instruction", bus.instruction, e_instr);
  endtask

  task automatic drive(input bit r, input bit e, input bit rd, input bit wr, input bit lk,
                       input logic [15:0] a, input logic [15:0] wd, input logic [9:0] p,
                       input logic [3:0] pv, input logic [63:0] pin);
    rst = r; bus.en = e; bus.memread = rd; bus.memwrite = wr; bus.link = lk;
    bus.adr = a; bus.writedata = wd; bus.pc = p; player_valid = pv; player_in = pin;
    model_cycle();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 16'h0, 16'h0, 10'h0, 4'h0, 64'h0);
  endtask

  initial begin
    logic [15:0] a;
    bit zero_seen;
    for (int i = 0; i < 1024; i++) m_init[i] = 0;

    // Reset, then RAND read on the first active cycle.
    drive(0, 1, 1, 0, 0, 16'hFF00, 16'h0, 10'h0, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 10'h0, 4'h0, 64'h0);
    chk("reset_memdata", bus.memdata, 16'h0);
    chk("reset_psnap", p_snap, 64'h0);
    drive(1, 1, 1, 0, 0, 16'hFF00, 16'h0, 10'h0, 4'h0, 64'h0);
    chk("rand_first", bus.memdata, 16'hACE1);

    // Fill low RAM so fetches have known contents.
    for (int i = 0; i < 16; i++)
      drive(1, 1, 0, 1, 0, 16'(i), 16'($urandom), 10'(i), 4'h0, 64'h0);

    // Plain write then read.
    drive(1, 1, 0, 1, 0, 16'd5, 16'h1234, 10'd5, 4'h0, 64'h0);
    drive(1, 1, 1, 0, 0, 16'd5, 16'h0, 10'd5, 4'h0, 64'h0);
    chk("t1_read", bus.memdata, 16'h1234);
    chk("t1_aerr", bus.addr_err, 1'b0);
    chk("t1_fetch", bus.instruction, 16'h1234);

    // Read-before-write on the data port.
    drive(1, 1, 0, 1, 0, 16'd7, 16'hAAAA, 10'd0, 4'h0, 64'h0);
    drive(1, 1, 1, 1, 0, 16'd7, 16'h5555, 10'd7, 4'h0, 64'h0);
    chk("t2_old", bus.memdata, 16'hAAAA);
    chk("t2_fetch_old", bus.instruction, 16'hAAAA);
    drive(1, 1, 1, 0, 0, 16'd7, 16'h0, 10'd7, 4'h0, 64'h0);
    chk("t2_new", bus.memdata, 16'h5555);

    // Link beats read and wraps.
    drive(1, 1, 1, 0, 1, 16'd5, 16'h0, 10'h3FF, 4'h0, 64'h0);
    chk("t3_link", bus.memdata, 16'h0000);
    drive(1, 1, 0, 0, 1, 16'd5, 16'h0, 10'h010, 4'h0, 64'h0);
    chk("t3_link_inc", bus.memdata, 16'h0011);

    // Sticky flag set, read-to-clear.
    drive(1, 0, 0, 0, 0, 16'h0, 16'h0, 10'h0, 4'h4, 64'h0000_00C3_0000_0000);
    drive(1, 1, 1, 0, 0, 16'hFF01, 16'h0, 10'h0, 4'h0, 64'h0);
    chk("t4_status", bus.memdata, 16'h0004);
    drive(1, 1, 1, 0, 0, 16'hFF06, 16'h0, 10'h0, 4'h0, 64'h0);
    chk("t4_player", bus.memdata, 16'h00C3);
    drive(1, 1, 1, 0, 0, 16'hFF01, 16'h0, 10'h0, 4'h0, 64'h0);
    chk("t4_status_clr", bus.memdata, 16'h0000);

    // Set wins against FLAG_CLR.
    drive(1, 1, 0, 1, 0, 16'hFF03, 16'h000F, 10'h0, 4'h2, 64'h0000_0000_0077_0000);
    drive(1, 1, 1, 0, 0, 16'hFF01, 16'h0, 10'h0, 4'h0, 64'h0);
    chk("t5_status", bus.memdata, 16'h0002);

    // SNAP capture, then back-to-back SNAPs.
    drive(1, 0, 0, 0, 0, 16'h0, 16'h0, 10'h0, 4'hF, 64'h0004_0003_0002_0001);
    drive(1, 1, 0, 1, 0, 16'hFF02, 16'h0BEE, 10'h0, 4'h0, 64'h0);
    chk("t6_valid", snap_valid, 1'b1);
    chk("t6_rand", randomVal, 16'h0BEE);
    chk("t6_psnap", p_snap, 64'h0004_0003_0002_0001);
    drive(1, 1, 1, 0, 0, 16'hFF01, 16'h0, 10'h0, 4'h0, 64'h0);
    chk("t6_status", bus.memdata, 16'h0000);
    chk("t6_pulse_end", snap_valid, 1'b0);
    drive(1, 1, 0, 1, 0, 16'hFF02, 16'h1111, 10'h0, 4'h0, 64'h0);
    drive(1, 1, 0, 1, 0, 16'hFF02, 16'h2222, 10'h0, 4'h0, 64'h0);
    chk("t6_b2b", snap_valid, 1'b1);
    chk("t6_b2b_rand", randomVal, 16'h2222);

    // Unmapped read just past the last player register.
    drive(1, 1, 1, 0, 0, 16'hFF08, 16'h0, 10'h0, 4'h0, 64'h0);
    chk("t7_data", bus.memdata, 16'h0000);
    chk("t7_aerr", bus.addr_err, 1'b1);
    idle();
    chk("t7_aerr_end", bus.addr_err, 1'b0);

    // Random traffic across RAM, the I/O window and unmapped space.
    for (int n = 0; n < 1500; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      a = 16'($urandom_range(0, 15));
      else if (sel <= 8) a = 16'hFF00 + 16'($urandom_range(0, 9));
      else               a = ($urandom_range(0, 1) == 1) ? 16'h0400 + 16'($urandom_range(0, 255))
                                                       : 16'hFE00 + 16'($urandom_range(0, 255));
      drive(1, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 15) == 0), a, 16'($urandom), 10'($urandom_range(0, 15)),
            4'($urandom), {$urandom, $urandom});
    end

    // Reset in the cycle after a SNAP and a read cancels both.
    drive(1, 1, 0, 1, 0, 16'hFF02, 16'h3333, 10'h0, 4'h0, 64'h0);
    chk("rst_pre_snap", snap_valid, 1'b1);
    drive(0, 1, 1, 0, 0, 16'd5, 16'h0, 10'h0, 4'h0, 64'h0);
    chk("rst_mid_snap", snap_valid, 1'b0);
    chk("rst_mid_rand", randomVal, 16'h0);
    chk("rst_mid_data", bus.memdata, 16'h0);

    // Full LFSR period: RAND never reads zero.
    zero_seen = 0;
    for (int n = 0; n < 65535; n++) begin
      drive(1, 1, 1, 0, 0, 16'hFF00, 16'h0, 10'h0, 4'h0, 64'h0);
      if (bus.memdata == 16'h0) zero_seen = 1;
    end
    chk("lfsr_nonzero", 64'(zero_seen), 64'h0);
    drive(1, 1, 1, 0, 0, 16'hFF00, 16'h0, 10'h0, 4'h0, 64'h0);
    chk("lfsr_period", bus.memdata, 16'hACE1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
